// File: rtl/key_code_capture.sv
// Debounced key-event capture behind an active-low 8-to-3 priority encoder.
// Qualified presses are queued in a 4-entry first-word-fall-through FIFO.
module key_code_capture #(
   parameter int DEB_CYCLES = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       GS,
   input  logic [2:0] Code,
   input  logic       Ready,
   output logic       Valid,
   output logic [2:0] Key,
   output logic [2:0] Count,
   output logic       Full,
   output logic       Overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HELD = 2'd2,
      REL  = 2'd3
   } state_t;

   localparam logic [3:0] DEB_L  = 4'(DEB_CYCLES);
   localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

   // synchronizer stage 1 and stage 2 (GS_s / Code_s)
   logic       gs_s1_q, gs_s_q;
   logic [2:0] code_s1_q, code_s_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         gs_s1_q   <= 1'b1;
         gs_s_q    <= 1'b1;
         code_s1_q <= 3'b111;
         code_s_q  <= 3'b111;
      end else begin
         gs_s1_q   <= GS;
         gs_s_q    <= gs_s1_q;
         code_s1_q <= Code;
         code_s_q  <= code_s1_q;
      end
   end

   // debounce FSM; push request is registered, so the FIFO write lands one edge later
   state_t     state_q;
   logic [3:0] cnt_q;
   logic [3:0] cnt_inc;
   logic [2:0] lat_q;
   logic       push_q;
   logic [2:0] push_key_q;

   assign cnt_inc = cnt_q + 4'd1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         lat_q   <= 3'b111;
         push_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!gs_s_q) begin
                  state_q <= QUAL;
                  lat_q   <= code_s_q;
                  cnt_q   <= 4'd1;
               end
            end
            QUAL: begin
               if (gs_s_q) begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end else if (code_s_q != lat_q) begin
                  lat_q <= code_s_q;
                  cnt_q <= 4'd1;
               end else if (cnt_inc == DEB_L) begin
                  push_q     <= 1'b1;
                  push_key_q <= ~lat_q;
                  cnt_q      <= cnt_inc;
                  state_q    <= HELD;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            HELD: begin
               if (gs_s_q) begin
                  state_q <= REL;
                  cnt_q   <= 4'd1;
               end else if (code_s_q != lat_q) begin
                  state_q <= QUAL;
                  lat_q   <= code_s_q;
                  cnt_q   <= 4'd1;
               end
            end
            REL: begin
               if (!gs_s_q) begin
                  if (code_s_q == lat_q) begin
                     state_q <= HELD;
                  end else begin
                     state_q <= QUAL;
                     lat_q   <= code_s_q;
                     cnt_q   <= 4'd1;
                  end
               end else if (cnt_inc == DEB_L) begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // event queue
   logic [2:0] mem_q [4];
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       ovf_q, ovf_d;
   logic       pop, full, wr_en;

   assign full  = (count_q == DEPTH_L);
   assign pop   = (count_q != 3'd0) && Ready;
   // a full queue still accepts a push when the head leaves on the same edge
   assign wr_en = push_q && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (push_q & full & ~pop);
      if (wr_en) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop)   rd_ptr_d = rd_ptr_q + 2'd1;
      if (wr_en && !pop) count_d = count_q + 3'd1;
      else if (pop && !wr_en) count_d = count_q - 3'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_key_q;
   end

   assign Valid    = (count_q != 3'd0);
   assign Key      = Valid ? mem_q[rd_ptr_q] : 3'd0;
   assign Count    = count_q;
   assign Full     = full;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_key_code_capture.sv
// Directed bench for key_code_capture: vector table plus latency/reset sequences.
module tb_key_code_capture;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       GS = 1'b1;
   logic [2:0] Code = 3'b111;
   logic       Ready = 1'b0;
   logic       Valid;
   logic [2:0] Key;
   logic [2:0] Count;
   logic       Full;
   logic       Overflow;

   int checks = 0;
   int failures = 0;

   key_code_capture #(.DEB_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .GS(GS), .Code(Code), .Ready(Ready),
      .Valid(Valid), .Key(Key), .Count(Count), .Full(Full), .Overflow(Overflow)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic       gs;
      logic [2:0] code;
      logic       ready;
      int         n;
      logic       valid;
      logic [2:0] key;
      logic [2:0] count;
      logic       full;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic gs, input logic [2:0] code,
                      input logic ready, input int n, input logic valid,
                      input logic [2:0] key, input logic [2:0] count,
                      input logic full, input logic ovf);
      vec_t v;
      v.rst = rst; v.gs = gs; v.code = code; v.ready = ready; v.n = n;
      v.valid = valid; v.key = key; v.count = count; v.full = full; v.ovf = ovf;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_all(input string tag, input logic valid, input logic [2:0] key,
                            input logic [2:0] count, input logic full, input logic ovf);
      check({tag, ".Valid"}, int'(Valid), int'(valid));
      check({tag, ".Key"}, int'(Key), int'(key));
      check({tag, ".Count"}, int'(Count), int'(count));
      check({tag, ".Full"}, int'(Full), int'(full));
      check({tag, ".Overflow"}, int'(Overflow), int'(ovf));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // press (8 edges) then release (8 edges) with hand-computed queue state
   task automatic press_release(input logic [2:0] code, input logic [2:0] head,
                                input logic [2:0] cnt, input logic ovf);
      add(0, 0, code, 0, 8, 1, head, cnt, cnt == 3'd4, ovf);
      add(0, 1, 3'b111, 0, 8, 1, head, cnt, cnt == 3'd4, ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      RST = 1'b1; GS = 1'b1; Code = 3'b111; Ready = 1'b0;
      step(2);
      RST = 1'b0;
      check_all("reset", 0, 0, 0, 0, 0);

      // clean press latency: Valid rises exactly after edge 6
      GS = 1'b0; Code = 3'b010;
      for (int e = 0; e < 8; e++) begin
         step(1);
         check($sformatf("latency.e%0d", e), int'(Valid), (e >= 6) ? 1 : 0);
      end
      check("latency.Key", int'(Key), 5);
      check("latency.Count", int'(Count), 1);

      // held key: no repeat push; clean release; pop; Ready on empty queue
      add(0, 0, 3'b010, 0, 10, 1, 5, 1, 0, 0);
      add(0, 1, 3'b111, 0, 8, 1, 5, 1, 0, 0);
      add(0, 1, 3'b111, 1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 3'b111, 1, 3, 0, 0, 0, 0, 0);
      // 2-cycle glitch: never qualifies
      add(0, 0, 3'b010, 0, 2, 0, 0, 0, 0, 0);
      add(0, 1, 3'b111, 0, 10, 0, 0, 0, 0, 0);
      // press, 2-cycle release bounce back to same key, then clean release
      add(0, 0, 3'b010, 0, 8, 1, 5, 1, 0, 0);
      add(0, 1, 3'b111, 0, 2, 1, 5, 1, 0, 0);
      add(0, 0, 3'b010, 0, 10, 1, 5, 1, 0, 0);
      add(0, 1, 3'b111, 0, 8, 1, 5, 1, 0, 0);
      add(0, 1, 3'b111, 1, 1, 0, 0, 0, 0, 0);
      // five presses with Ready low: fifth is dropped
      press_release(3'b110, 1, 1, 0);
      press_release(3'b101, 1, 2, 0);
      press_release(3'b100, 1, 3, 0);
      press_release(3'b011, 1, 4, 0);
      press_release(3'b001, 1, 4, 1);
      add(0, 1, 3'b111, 1, 1, 1, 2, 3, 0, 1);
      add(0, 1, 3'b111, 1, 1, 1, 3, 2, 0, 1);
      add(0, 1, 3'b111, 1, 1, 1, 4, 1, 0, 1);
      add(0, 1, 3'b111, 1, 1, 0, 0, 0, 0, 1);
      add(0, 1, 3'b111, 1, 2, 0, 0, 0, 0, 1);
      // reset clears sticky overflow
      add(1, 1, 3'b111, 0, 2, 0, 0, 0, 0, 0);
      // full queue with push and pop on the same edge
      press_release(3'b110, 1, 1, 0);
      press_release(3'b101, 1, 2, 0);
      press_release(3'b100, 1, 3, 0);
      press_release(3'b011, 1, 4, 0);
      add(0, 0, 3'b001, 0, 6, 1, 1, 4, 1, 0);
      add(0, 0, 3'b001, 1, 1, 1, 2, 4, 1, 0);
      add(0, 0, 3'b001, 0, 4, 1, 2, 4, 1, 0);
      add(0, 1, 3'b111, 0, 8, 1, 2, 4, 1, 0);
      add(0, 1, 3'b111, 1, 1, 1, 3, 3, 0, 0);
      add(0, 1, 3'b111, 1, 1, 1, 4, 2, 0, 0);
      add(0, 1, 3'b111, 1, 1, 1, 6, 1, 0, 0);
      add(0, 1, 3'b111, 1, 1, 0, 0, 0, 0, 0);
      // leave one entry queued for the reset sequence below
      add(0, 0, 3'b100, 0, 8, 1, 3, 1, 0, 0);
      add(0, 1, 3'b111, 0, 8, 1, 3, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         RST = vecs[i].rst; GS = vecs[i].gs; Code = vecs[i].code; Ready = vecs[i].ready;
         step(vecs[i].n);
         check_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].key,
                   vecs[i].count, vecs[i].full, vecs[i].ovf);
      end

      // reset mid-qualification with a non-empty queue
      RST = 1'b0; Ready = 1'b0; GS = 1'b0; Code = 3'b010;
      step(4);
      check("midqual.Count", int'(Count), 1);
      RST = 1'b1;
      step(2);
      check_all("midqual_rst", 0, 0, 0, 0, 0);
      RST = 1'b0;
      for (int e = 0; e < 8; e++) begin
         step(1);
         check($sformatf("requal.e%0d", e), int'(Valid), (e >= 6) ? 1 : 0);
      end
      check("requal.Key", int'(Key), 5);
      check("requal.Count", int'(Count), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
